// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipe_gate skid stage.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

endpackage

// File: rtl/pipe_gate_if.sv
// Valid/ready payload channel; the master drives valid/data, the slave drives ready.
interface pipe_gate_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous active-low clear and increment enable.
module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_clr_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!i_clr_n)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != {W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_gate.sv
// Two-entry skid pipeline gate with flush; optional stall/bubble counters
// built when PIPE_GATE_PERF_CNT_EN is defined.
module pipe_gate
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RST_DATA = '0
`ifdef PIPE_GATE_PERF_CNT_EN
  ,
  parameter int                CNT_W    = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  pipe_gate_if.slave        up,
  pipe_gate_if.master       dn
`ifdef PIPE_GATE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  logic w_up_ready;
  logic w_dn_valid;
  logic w_up_xfer;
  logic w_dn_xfer;
  logic w_main_ld_up;
  logic w_main_ld_skid;
  logic w_skid_ld;

  // Handshake outputs decode from state only, so no ready/valid comb loop.
  assign w_up_ready = (r_state != TWO);
  assign w_dn_valid = (r_state != EMPTY);
  assign w_up_xfer  = up.valid & w_up_ready;
  assign w_dn_xfer  = w_dn_valid & dn.ready;

  assign up.ready = w_up_ready;
  assign dn.valid = w_dn_valid;
  assign dn.data  = r_main;

  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_up   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_up_xfer) begin
          w_main_ld_up = 1'b1;
          w_state_nxt  = ONE;
        end
      end
      ONE: begin
        if (w_up_xfer && w_dn_xfer) begin
          w_main_ld_up = 1'b1;
        end else if (w_up_xfer) begin
          w_skid_ld   = 1'b1;
          w_state_nxt = TWO;
        end else if (w_dn_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_dn_xfer) begin
          w_main_ld_skid = 1'b1;
          w_state_nxt    = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Reset and flush both drop every held payload; only reset clears counters.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state <= EMPTY;
      r_main  <= RST_DATA;
      r_skid  <= RST_DATA;
    end else begin
      r_state <= w_state_nxt;
      if (w_main_ld_up)
        r_main <= up.data;
      else if (w_main_ld_skid)
        r_main <= r_skid;
      if (w_skid_ld)
        r_skid <= up.data;
    end
  end

`ifdef PIPE_GATE_PERF_CNT_EN
  logic w_stall_inc;
  logic w_bubble_inc;

  assign w_stall_inc  = w_dn_valid & ~dn.ready;
  assign w_bubble_inc = ~w_dn_valid & dn.ready;

  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .i_clr_n (rst_n),
    .i_inc   (w_stall_inc),
    .o_cnt   (stall_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk     (clk),
    .i_clr_n (rst_n),
    .i_inc   (w_bubble_inc),
    .o_cnt   (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_gate.sv
// Directed and randomized scoreboard bench for pipe_gate; counter checks
// compile in when PIPE_GATE_PERF_CNT_EN is defined.
module tb_pipe_gate;

  localparam int          DW  = 32;
  localparam logic [31:0] RST = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  pipe_gate_if #(.DATA_W(DW)) u_up ();
  pipe_gate_if #(.DATA_W(DW)) u_dn ();

`ifdef PIPE_GATE_PERF_CNT_EN
  logic [3:0] stall_cnt;
  logic [3:0] bubble_cnt;
`endif

  pipe_gate #(
    .DATA_W   (DW),
    .RST_DATA (RST)
`ifdef PIPE_GATE_PERF_CNT_EN
    ,
    .CNT_W    (4)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .up         (u_up.slave),
    .dn         (u_dn.master)
`ifdef PIPE_GATE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    u_up.valid = v;
    u_up.data  = d;
    u_dn.ready = r;
  endtask

  logic [31:0] q[$];
  logic [31:0] rd;
  logic        rv, rr, rf;

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick(); tick();
    chk("rst_dn_valid", {31'b0, u_dn.valid}, 32'd0);
    chk("rst_up_ready", {31'b0, u_up.ready}, 32'd1);
    chk("rst_dn_data", u_dn.data, RST);
`ifdef PIPE_GATE_PERF_CNT_EN
    chk("rst_stall", {28'b0, stall_cnt}, 32'd0);
    chk("rst_bubble", {28'b0, bubble_cnt}, 32'd0);
`endif

    // back-to-back streaming at full throughput
    rst_n = 1'b1;
    drive(1'b1, 32'h11, 1'b1); tick();
    chk("s1_data", u_dn.data, 32'h11);
    chk("s1_valid", {31'b0, u_dn.valid}, 32'd1);
    chk("s1_ready", {31'b0, u_up.ready}, 32'd1);
    drive(1'b1, 32'h22, 1'b1); tick();
    chk("s2_data", u_dn.data, 32'h22);
    chk("s2_ready", {31'b0, u_up.ready}, 32'd1);
    drive(1'b1, 32'h33, 1'b1); tick();
    chk("s3_data", u_dn.data, 32'h33);
    chk("s3_valid", {31'b0, u_dn.valid}, 32'd1);
    drive(1'b0, 32'h0, 1'b1); tick();
    chk("s4_drained", {31'b0, u_dn.valid}, 32'd0);
`ifdef PIPE_GATE_PERF_CNT_EN
    chk("s4_bubble", {28'b0, bubble_cnt}, 32'd1);
`endif

    // fill both entries under backpressure, then drain
    drive(1'b1, 32'hA, 1'b0); tick();
    chk("bp1_data", u_dn.data, 32'hA);
    chk("bp1_ready", {31'b0, u_up.ready}, 32'd1);
    drive(1'b1, 32'hB, 1'b0); tick();
    chk("bp2_ready", {31'b0, u_up.ready}, 32'd0);
    chk("bp2_data", u_dn.data, 32'hA);
    drive(1'b1, 32'hEE, 1'b0); tick();
    chk("bp3_hold", u_dn.data, 32'hA);
    chk("bp3_ready", {31'b0, u_up.ready}, 32'd0);
    drive(1'b0, 32'h0, 1'b1); tick();
    chk("dr1_data", u_dn.data, 32'hB);
    chk("dr1_ready", {31'b0, u_up.ready}, 32'd1);
    tick();
    chk("dr2_valid", {31'b0, u_dn.valid}, 32'd0);
`ifdef PIPE_GATE_PERF_CNT_EN
    chk("dr2_stall", {28'b0, stall_cnt}, 32'd2);
`endif

    // flush from TWO with a concurrent push
    drive(1'b1, 32'hA, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0); tick();
    chk("fl0_ready", {31'b0, u_up.ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'hC, 1'b0); tick();
    chk("fl1_valid", {31'b0, u_dn.valid}, 32'd0);
    chk("fl1_data", u_dn.data, RST);
    chk("fl1_ready", {31'b0, u_up.ready}, 32'd1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1); tick();
    chk("fl2_valid", {31'b0, u_dn.valid}, 32'd0);
`ifdef PIPE_GATE_PERF_CNT_EN
    chk("fl2_stall", {28'b0, stall_cnt}, 32'd4);
    chk("fl2_bubble", {28'b0, bubble_cnt}, 32'd2);
`endif

    // reset beats a simultaneous flush and push
    drive(1'b1, 32'h77, 1'b0); tick();
    chk("rf0_data", u_dn.data, 32'h77);
    rst_n = 1'b0; flush = 1'b1;
    drive(1'b1, 32'h88, 1'b0); tick();
    chk("rf1_valid", {31'b0, u_dn.valid}, 32'd0);
    chk("rf1_ready", {31'b0, u_up.ready}, 32'd1);
    chk("rf1_data", u_dn.data, RST);
`ifdef PIPE_GATE_PERF_CNT_EN
    chk("rf1_stall", {28'b0, stall_cnt}, 32'd0);
    chk("rf1_bubble", {28'b0, bubble_cnt}, 32'd0);
`endif

    // long stall: counter saturation, flush leaves counters alone
    rst_n = 1'b1; flush = 1'b0;
    drive(1'b1, 32'h99, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("st_hold", u_dn.data, 32'h99);
`ifdef PIPE_GATE_PERF_CNT_EN
    chk("st_sat", {28'b0, stall_cnt}, 32'd15);
`endif
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("st_fl_valid", {31'b0, u_dn.valid}, 32'd0);
`ifdef PIPE_GATE_PERF_CNT_EN
    chk("st_fl_sat", {28'b0, stall_cnt}, 32'd15);
`endif

    // randomized traffic against a FIFO scoreboard
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 3) != 0);
      rf = ($urandom_range(0, 63) == 0);
      rd = $urandom;
      drive(rv, rd, rr);
      flush = rf;
      chk("rnd_valid", {31'b0, u_dn.valid}, {31'b0, (q.size() != 0)});
      chk("rnd_ready", {31'b0, u_up.ready}, {31'b0, (q.size() < 2)});
      if (q.size() != 0 && rr) begin
        chk("rnd_data", u_dn.data, q[0]);
        void'(q.pop_front());
      end
      if (rv && u_up.ready) q.push_back(rd);
      if (rf) q.delete();
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
